// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline sequencer for the 5-stage RV32 core.
//
// It decides each cycle how the pipeline registers advance. The cases, in
// priority order, are:
//   - freeze the whole pipeline while a data-memory access is not ready,
//   - apply a control-flow redirect resolved in EX,
//   - insert a single bubble for a load-use hazard between ID and EX,
//   - otherwise let everything advance.
// A data access that stays not-ready for MEM_TIMEOUT consecutive cycles
// halts the core until reset. Saturating counters record stall, flush and
// memory-wait cycles.
//
// Parameters:
//   MEM_TIMEOUT  consecutive not-ready cycles before halting (>= 2)
//   CNT_W        performance counter width
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_*    source operands of the ID instruction
//   ex_mem_read, ex_rd          load-in-EX indication and its destination
//   ex_redirect                 taken branch / jal / jalr resolved in EX
//   dmem_req, dmem_ready        data-memory handshake of the MEM stage
//   perf_clr                    synchronous clear of all counters
//   pc_en, pc_redirect          PC update enable, select the EX target
//   if_id_en, if_id_flush       IF/ID enable, IF/ID bubble insert
//   id_ex_stall, id_ex_flush    ID/EX hold, ID/EX bubble insert
//   ex_mem_en                   EX/MEM enable
//   mem_wb_bubble               write a NOP into MEM/WB
//   halted                      sticky memory-timeout fault
//   stall_cnt/flush_cnt/memwait_cnt  saturating performance counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The RUN entry cycle is the first not-ready cycle and wait_cnt starts at 0
  // in MEM_WAIT, so the MEM_TIMEOUT-th not-ready cycle sees MEM_TIMEOUT-2.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   memwait_cnt_q, memwait_cnt_d;

  logic mem_stall;
  logic load_use;
  logic ev_freeze;
  logic ev_redirect;
  logic ev_load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v,
                                                input logic clr,
                                                input logic ev);
    if (clr)     return '0;
    else if (ev) return sat_inc(v);
    else         return v;
  endfunction

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Response selection and pipeline-control outputs
  always_comb begin
    pc_en         = 1'b1;
    pc_redirect   = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    ev_freeze     = 1'b0;
    ev_redirect   = 1'b0;
    ev_load_use   = 1'b0;

    if (state_q == HALT || mem_stall) begin
      ev_freeze = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is on the wrong path, so load-use is moot.
      ev_redirect = 1'b1;
    end else if (load_use) begin
      ev_load_use = 1'b1;
    end

    if (ev_freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_stall   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ev_redirect) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ev_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    // Hold the pipeline empty while reset is asserted.
    if (reset) begin
      pc_en         = 1'b0;
      pc_redirect   = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  // Next state, timeout counter and performance counters
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase

    stall_cnt_d   = cnt_next(stall_cnt_q,   perf_clr, ev_load_use);
    flush_cnt_d   = cnt_next(flush_cnt_q,   perf_clr, ev_redirect);
    memwait_cnt_d = cnt_next(memwait_cnt_q, perf_clr, ev_freeze);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
// Control outputs are packed as
// {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_stall, id_ex_flush,
//  ex_mem_en, mem_wb_bubble, halted}.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam logic [8:0] C_DEF  = 9'b1_0_1_0_0_0_1_0_0;
  localparam logic [8:0] C_FRZ  = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] C_RED  = 9'b1_1_1_1_0_1_1_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] C_HLT  = 9'b0_0_0_0_1_0_0_1_1;
  localparam logic [8:0] C_RST  = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] C_RSTH = 9'b0_0_0_1_0_1_0_1_1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             dmem_req, dmem_ready, perf_clr;
  logic             pc_en, pc_redirect, if_id_en, if_id_flush;
  logic             id_ex_stall, id_ex_flush, ex_mem_en, mem_wb_bubble, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
  logic [8:0]       ctl;

  int vectors     = 0;
  int miscompares = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_en, mem_wb_bubble, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_redirect = 0;
    dmem_req = 0; dmem_ready = 0; perf_clr = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    #1;
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    check("reset_memwait_cnt", 32'(memwait_cnt), 0);
    tick();
    reset = 1'b0;
    #1;
    check("idle_default", 32'(ctl), 32'(C_DEF));

    // Load-use on rs1: lw x5 in EX, ID reads x5
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1 check("loaduse_rs1", 32'(ctl), 32'(C_LU));
    tick();
    ex_mem_read = 0; ex_rd = 0;
    #1 check("loaduse_release", 32'(ctl), 32'(C_DEF));
    check("stall_cnt_1", 32'(stall_cnt), 1);
    tick();

    // Load to x0 never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1 check("loaduse_x0", 32'(ctl), 32'(C_DEF));
    tick();
    check("stall_cnt_x0", 32'(stall_cnt), 1);

    // Load-use on rs2, and a match on an unused rs2
    idle();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    #1 check("loaduse_rs2", 32'(ctl), 32'(C_LU));
    tick();
    id_uses_rs2 = 0;
    #1 check("rs2_unused", 32'(ctl), 32'(C_DEF));
    tick();
    check("stall_cnt_2", 32'(stall_cnt), 2);

    // Redirect overrides load-use
    idle();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_redirect = 1;
    #1 check("redirect_over_lu", 32'(ctl), 32'(C_RED));
    tick();
    idle();
    check("stall_cnt_after_redir", 32'(stall_cnt), 2);
    check("flush_cnt_1", 32'(flush_cnt), 1);

    // Memory wait: 3 not-ready cycles, with a load-use present to show freeze wins
    dmem_req = 1; dmem_ready = 0;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    #1 check("memwait_c1", 32'(ctl), 32'(C_FRZ));
    tick();
    check("memwait_c2", 32'(ctl), 32'(C_FRZ));
    tick();
    check("memwait_c3", 32'(ctl), 32'(C_FRZ));
    tick();
    idle();
    dmem_req = 1; dmem_ready = 1;
    #1 check("memwait_release", 32'(ctl), 32'(C_DEF));
    check("memwait_cnt_3", 32'(memwait_cnt), 3);
    tick();
    idle();
    #1 check("memwait_back_run", 32'(ctl), 32'(C_DEF));

    // Freeze with a pending redirect: redirect applies on the release cycle
    ex_redirect = 1; dmem_req = 1; dmem_ready = 0;
    #1 check("frz_redir_c1", 32'(ctl), 32'(C_FRZ));
    tick();
    check("frz_redir_c2", 32'(ctl), 32'(C_FRZ));
    tick();
    dmem_ready = 1;
    #1 check("frz_redir_release", 32'(ctl), 32'(C_RED));
    tick();
    idle();
    check("flush_cnt_2", 32'(flush_cnt), 2);
    check("memwait_cnt_5", 32'(memwait_cnt), 5);

    // Timeout: 4 not-ready cycles halt the core
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("timeout_c%0d", i), 32'(ctl), 32'(C_FRZ));
      tick();
    end
    dmem_ready = 1;
    #1 check("halt_1", 32'(ctl), 32'(C_HLT));
    tick();
    dmem_req = 0; ex_redirect = 1;
    #1 check("halt_2", 32'(ctl), 32'(C_HLT));
    tick();
    check("memwait_cnt_halt", 32'(memwait_cnt), 11);
    check("flush_cnt_halt", 32'(flush_cnt), 2);
    idle();
    reset = 1;
    #1 check("reset_in_halt", 32'(ctl), 32'(C_RSTH));
    tick();
    reset = 0;
    #1 check("after_reset_run", 32'(ctl), 32'(C_DEF));
    check("after_reset_memwait", 32'(memwait_cnt), 0);

    // Counter saturation: 20 redirect cycles
    ex_redirect = 1;
    for (int i = 0; i < 20; i++) tick();
    check("flush_cnt_sat", 32'(flush_cnt), 15);
    tick();
    check("flush_cnt_hold", 32'(flush_cnt), 15);
    perf_clr = 1;
    #1 check("clr_cycle_redirect", 32'(ctl), 32'(C_RED));
    tick();
    check("flush_cnt_clr", 32'(flush_cnt), 0);
    idle();
    tick();
    check("flush_cnt_idle", 32'(flush_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline sequencer for the 5-stage RV32 core. It detects load-use hazards between ID and EX and applies control-flow redirects resolved in EX. It freezes the whole pipeline while the data-memory port is waiting, and halts the core on a memory timeout. It drives the enable, stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready cycles of an outstanding data access (≥2) before the core halts.
- CNT_W, 32: performance counter width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1 / rs2.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr.
- dmem_req  in  1  the instruction in MEM is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- perf_clr  in  1  synchronously clears all counters.
- pc_en  out  1  PC register update enable.
- pc_redirect  out  1  select the EX target as next PC.
- if_id_en, if_id_flush  out  1  IF/ID enable; IF/ID bubble insert.
- id_ex_stall, id_ex_flush  out  1  ID/EX hold; ID/EX bubble insert.
- ex_mem_en  out  1  EX/MEM enable.
- mem_wb_bubble  out  1  write a NOP into MEM/WB.
- halted  out  1  sticky fault flag; the core is frozen.
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters.

## Operation
- States: RUN, MEM_WAIT, HALT. The state register is clocked; all pipeline-control outputs are combinational from the state and the current inputs.
- **Freeze** means pc_en=0, if_id_en=0, id_ex_stall=1, ex_mem_en=0, mem_wb_bubble=1, and all flushes 0.
- **Redirect** means pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_en=1.
- **Load-use** applies when ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). It drives pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
- **Default** is all enables 1, and all stall, flush and bubble outputs 0.
- Priority in RUN and MEM_WAIT: freeze (dmem_req && !dmem_ready) > redirect > load-use > default.
  - A redirect suppresses load-use, because the ID instruction is on the wrong path.
  - A redirect during a freeze is held in ID/EX and applied on the release cycle.
- HALT: freeze forever and halted=1. Only reset exits HALT.
- Transitions:
  - RUN→MEM_WAIT when dmem_req && !dmem_ready.
  - MEM_WAIT→RUN when dmem_ready.
  - MEM_WAIT→HALT when dmem_ready has been low for MEM_TIMEOUT consecutive cycles. The RUN entry cycle counts as cycle 1.
- wait_cnt is an internal counter that is cleared on the RUN→MEM_WAIT edge and increments in MEM_WAIT.
- Counters saturate at 2^CNT_W−1 and never wrap.
  - stall_cnt increments on each load-use cycle.
  - flush_cnt increments on each redirect cycle.
  - memwait_cnt increments on each freeze cycle, including HALT.
  - perf_clr takes precedence over increment.
- Reset values: state=RUN, halted=0, all counters 0, wait_cnt 0.
  - While reset=1, outputs are forced to pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=0, mem_wb_bubble=1, pc_redirect=0.
  - Reset asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge.

## Timing
- Load-use costs exactly one bubble. The next cycle the load is in MEM, the comparison fails, and the default response applies, with no state change.
- Redirect: flushes are asserted in the EX-resolve cycle, giving a 2-instruction penalty. Back-to-back redirects flush on each cycle.
- Memory wait: the freeze is asserted combinationally in the first not-ready cycle. It is released in the same cycle that dmem_ready=1, and normal priority evaluation applies in that cycle.
- The halt decision is registered: halted rises on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle.
- Counter values appear one cycle after the counted event.

## Test plan
- Load-use hazard: lw x5 in EX (ex_mem_read=1, ex_rd=5), id_rs1=5, id_uses_rs1=1.
  - Expected: one cycle of pc_en=0, id_ex_flush=1.
  - Then stall_cnt=1.
  - The same stimulus with ex_rd=0 gives no stall.
- Redirect overrides load-use: ex_redirect=1 together with a load-use match.
  - Expected: pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_en=1.
  - stall_cnt unchanged; flush_cnt +1.
- Memory wait with MEM_TIMEOUT=4: dmem_req=1, dmem_ready low for 3 cycles, then high.
  - Expected: 3 freeze cycles and memwait_cnt=3; state back in RUN with the release cycle at default.
  - halted stays 0.
- Timeout with MEM_TIMEOUT=4: dmem_ready low for 4 cycles.
  - Expected: halted=1 on the following edge.
  - The core stays frozen even after dmem_ready=1.
  - reset then clears halted and returns to RUN.
- Freeze with pending redirect: ex_redirect=1 while dmem_ready is low for 2 cycles.
  - Expected: freeze wins for 2 cycles, then the redirect is applied on the release cycle.
- Counter saturation with CNT_W=4: 20 redirect cycles.
  - Expected: flush_cnt holds at 15.
  - perf_clr coincident with an event gives 0.
